// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared types and constants for the expansion-audio delta-sigma DAC
// Contents:
//   ramp_st_t  : gain ramp FSM states
//   GAIN_MAX   : full-scale ramp gain
//   LFSR_SEED  : dither LFSR reset value
//   LFSR_TAPS  : dither LFSR Galois feedback mask
package snd_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_st_t;

  localparam logic [7:0]  GAIN_MAX  = 8'd255;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR used for dither.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/snd_dsm_dac_if.sv
// rtl/snd_dsm_dac_if.sv - audio input / DAC output bundle for snd_dsm_dac
// Signals:
//   snd_in[6:0]     expansion audio level, unsigned
//   snd_stb         1-cycle strobe, snd_in valid
//   mute            1 = ramp gain to 0, 0 = ramp gain to full
//   master_vol[3:0] master volume, multiplier master_vol+1
//   pcm_out[15:0]   filtered PCM level
//   ramp_busy       gain ramp in progress
//   dac_out         delta-sigma bitstream
// Modports: master = audio source side, slave = DAC side.
interface snd_dsm_dac_if;
  logic [6:0]  snd_in;
  logic        snd_stb;
  logic        mute;
  logic [3:0]  master_vol;
  logic [15:0] pcm_out;
  logic        ramp_busy;
  logic        dac_out;

  modport master (
    output snd_in, snd_stb, mute, master_vol,
    input  pcm_out, ramp_busy, dac_out
  );

  modport slave (
    input  snd_in, snd_stb, mute, master_vol,
    output pcm_out, ramp_busy, dac_out
  );
endinterface

// File: rtl/snd_dsm1.sv
// rtl/snd_dsm1.sv - first-order delta-sigma modulator with optional dither
// Ports:
//   clk           system clock
//   rst_n         asynchronous reset, active low
//   quiet         (SND_DITHER_EN only) 1 = suppress dither so silence stays silent
//   pcm_in[15:0]  unsigned PCM level
//   dac_out       1-bit stream, density of 1s = level/65536
// Macro SND_DITHER_EN adds a 16-bit Galois LFSR whose low 3 bits are added
// to the level (saturating) before the accumulator.
import snd_pkg::*;

module snd_dsm1 (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SND_DITHER_EN
  input  logic        quiet,
`endif
  input  logic [15:0] pcm_in,
  output logic        dac_out
);

  logic [15:0] level;
  logic [15:0] acc;
  logic [16:0] sum;

`ifdef SND_DITHER_EN
  logic [15:0] lfsr;
  logic [16:0] dith_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign dith_sum = {1'b0, pcm_in} + (quiet ? 17'd0 : {14'd0, lfsr[2:0]});
  // Saturate so a near-full-scale level cannot wrap to a small one.
  assign level = dith_sum[16] ? 16'hFFFF : dith_sum[15:0];
`else
  assign level = pcm_in;
`endif

  // The carry out of the 16-bit accumulator is the output bit.
  assign sum = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= sum[15:0];
      dac_out <= sum[16];
    end
  end

endmodule

// File: rtl/snd_dsm_dac.sv
// rtl/snd_dsm_dac.sv - expansion-audio level to 1-bit delta-sigma DAC stream
// Parameters:
//   LPF_SHIFT  low-pass coefficient 2^-LPF_SHIFT (1..8)
//   RAMP_DIV   clk cycles per gain step during mute/unmute ramps (>=1)
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    snd_dsm_dac_if.slave: snd_in, snd_stb, mute, master_vol in;
//          pcm_out, ramp_busy, dac_out out
// Path: capture -> master volume x anti-pop gain -> one-pole low-pass -> DSM.
// Macro SND_DITHER_EN enables LFSR dither inside snd_dsm1.
import snd_pkg::*;

module snd_dsm_dac #(
  parameter int LPF_SHIFT = 4,
  parameter int RAMP_DIV  = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  snd_dsm_dac_if.slave bus
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  logic [6:0]         smp;
  logic [7:0]         gain;
  ramp_st_t           state;
  logic [PW-1:0]      presc;
  logic               busy;
  logic               step;
  logic [4:0]         vol_mul;
  logic [10:0]        lvl;
  logic [18:0]        prod;
  logic [15:0]        target;
  logic signed [17:0] y;
  logic signed [17:0] diff;

  // Capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
    end else if (bus.snd_stb) begin
      smp <= bus.snd_in;
    end
  end

  // Ramp FSM. A mute change and a ramp step in the same cycle both apply:
  // the gain moves one step and the direction flips.
  assign step = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUTED;
      gain  <= '0;
      presc <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        MUTED: begin
          gain  <= '0;
          presc <= '0;
          if (!bus.mute) begin
            state <= RAMP_UP;
            busy  <= 1'b1;
          end
        end
        RAMP_UP: begin
          presc <= step ? '0 : presc + 1'b1;
          if (step && gain != GAIN_MAX) begin
            gain <= gain + 8'd1;
          end
          if (bus.mute) begin
            state <= RAMP_DOWN;
            presc <= '0;
          end else if (step && gain >= GAIN_MAX - 8'd1) begin
            state <= ON;
            busy  <= 1'b0;
            presc <= '0;
          end
        end
        ON: begin
          gain  <= GAIN_MAX;
          presc <= '0;
          if (bus.mute) begin
            state <= RAMP_DOWN;
            busy  <= 1'b1;
          end
        end
        RAMP_DOWN: begin
          presc <= step ? '0 : presc + 1'b1;
          if (step && gain != 8'd0) begin
            gain <= gain - 8'd1;
          end
          if (!bus.mute) begin
            state <= RAMP_UP;
            presc <= '0;
          end else if (step && gain <= 8'd1) begin
            state <= MUTED;
            busy  <= 1'b0;
            presc <= '0;
          end
        end
        default: begin
          state <= MUTED;
          gain  <= '0;
          presc <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Scale: 127*16*255 >> 3 = 64770 fits 16 bits.
  assign vol_mul = {1'b0, bus.master_vol} + 5'd1;
  assign lvl     = 11'(smp) * 11'(vol_mul);
  assign prod    = 19'(lvl) * 19'(gain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else begin
      target <= 16'(prod >> 3);
    end
  end

  // One-pole low-pass. The arithmetic shift floors, so a falling output
  // always moves by at least 1 and reaches the target exactly.
  assign diff = $signed({2'b00, target}) - y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= y + (diff >>> LPF_SHIFT);
    end
  end

  assign bus.pcm_out   = y[15:0];
  assign bus.ramp_busy = busy;

`ifdef SND_DITHER_EN
  logic quiet;
  assign quiet = (y[15:0] == 16'd0) && (gain == 8'd0);
`endif

  snd_dsm1 u_dsm (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SND_DITHER_EN
    .quiet   (quiet),
`endif
    .pcm_in  (y[15:0]),
    .dac_out (bus.dac_out)
  );

endmodule
